// File: rtl/multdiv_pkg.sv
// Shared constants and state encoding for the sequential multiply/divide unit.
package multdiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/seq_multdiv_addsub.sv
// 33-bit adder/subtractor shared by the Booth step and the restoring-divide step.
module seq_multdiv_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);

    assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/seq_multdiv.sv
// Sequential signed multiplier (radix-2 Booth) and restoring divider, 32 iterations each,
// with one-cycle completion pulse and registered result/exception.
module seq_multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    import multdiv_pkg::*;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;      // Booth accumulator / divide partial remainder
    logic [WIDTH-1:0] mq;       // multiplier -> product low word / dividend -> quotient
    logic [WIDTH-1:0] opm;      // multiplicand or divisor magnitude
    logic             q_1;
    logic             is_div;
    logic             neg;
    logic             div_zero;

    logic [WIDTH:0]   as_a;
    logic [WIDTH:0]   as_b;
    logic [WIDTH:0]   as_y;
    logic             as_sub;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH-1:0] quot;
    logic             mult_ovf;
    logic             start;

    assign start = ctrl_MULT | ctrl_DIV;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        as_a   = {acc[WIDTH-1], acc};
        as_b   = {opm[WIDTH-1], opm};
        as_sub = ({mq[0], q_1} == 2'b10);
        if (state == DIV) begin
            as_a   = {acc, mq[WIDTH-1]};
            as_b   = {1'b0, opm};
            as_sub = 1'b1;
        end
    end

    seq_multdiv_addsub #(.W(WIDTH + 1)) u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (as_sub),
        .y   (as_y)
    );

    // Booth pairs 00/11 only shift; 01/10 shift the add/subtract result.
    assign booth_sum = (mq[0] ^ q_1) ? as_y : as_a;
    assign quot      = neg ? -mq : mq;
    // Product fits in 32 bits only when bits [63:31] are all copies of the sign.
    assign mult_ovf  = !((&{acc, mq[WIDTH-1]}) || !(|{acc, mq[WIDTH-1]}));

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            mq             <= '0;
            opm            <= '0;
            q_1            <= 1'b0;
            is_div         <= 1'b0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                cnt <= '0;
                acc <= '0;
                q_1 <= 1'b0;
                if (ctrl_MULT) begin
                    state    <= MULT;
                    is_div   <= 1'b0;
                    mq       <= data_operandB;
                    opm      <= data_operandA;
                    neg      <= 1'b0;
                    div_zero <= 1'b0;
                end else begin
                    // Divide by zero skips iteration and completes on the next edge.
                    state    <= (data_operandB == '0) ? DONE : DIV;
                    is_div   <= 1'b1;
                    mq       <= magnitude(data_operandA);
                    opm      <= magnitude(data_operandB);
                    neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    div_zero <= (data_operandB == '0);
                end
            end else begin
                case (state)
                    IDLE: ;
                    MULT: begin
                        acc <= booth_sum[WIDTH:1];
                        mq  <= {booth_sum[0], mq[WIDTH-1:1]};
                        q_1 <= mq[0];
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(ITER - 1)) state <= DONE;
                    end
                    DIV: begin
                        if (!as_y[WIDTH]) begin
                            acc <= as_y[WIDTH-1:0];
                            mq  <= {mq[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= as_a[WIDTH-1:0];
                            mq  <= {mq[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(ITER - 1)) state <= DONE;
                    end
                    DONE: begin
                        if (!is_div) begin
                            data_result    <= mq;
                            data_exception <= mult_ovf;
                        end else if (div_zero) begin
                            data_result    <= '0;
                            data_exception <= 1'b1;
                        end else begin
                            // Unsigned quotient 2^31 with like signs is the only overflow.
                            data_result    <= quot;
                            data_exception <= mq[WIDTH-1] & ~neg;
                        end
                        data_resultRDY <= 1'b1;
                        cnt            <= '0;
                        state          <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
